rc_ladder_iir: RTL

- Discrete-time digital equivalent of a cascaded RC ladder: STAGES first-order low-pass sections in series, each with the update y += (x - y) >>> k.
- Samples enter and leave through valid/ready handshakes.
- One shared arithmetic datapath is time-multiplexed across stages under a small FSM; one stage is evaluated per clock.
- Sits between a sample source and the digital output probe of mixed-mode simulation benches. It generalises the fixed two-section nested RC subcircuit to parametrised depth, width and runtime time constant.

---
 rtl/rc_ladder_iir_if.sv | 27 ++
 rtl/rc_ladder_iir.sv | 108 ++++++++++
 2 files changed

// File: rtl/rc_ladder_iir_if.sv
// Sample-stream interface for rc_ladder_iir.
//   in_valid/in_ready/in_data : input sample handshake (source -> filter)
//   k_shift                   : time-constant shift, qualified by the input accept
//   out_valid/out_ready/out_data : filtered sample handshake (filter -> sink)
// slave = filter side, master = source/sink side.
interface rc_ladder_iir_if #(
  parameter int DATA_W  = 16,
  parameter int SHIFT_W = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [DATA_W-1:0]  in_data;
  logic        [SHIFT_W-1:0] k_shift;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [DATA_W-1:0]  out_data;

  modport slave (
    input  in_valid, in_data, k_shift, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, k_shift, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/rc_ladder_iir.sv
// Cascaded first-order low-pass (digital RC ladder). Each of STAGES sections
// applies y += (x - y) >>> k; one shared adder/shifter evaluates one section
// per clock, feeding each section's new state into the next.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero all section states (only acted on while idle)
//   busy       : high whenever a sample is in flight or waiting at the output
//   bus        : sample in/out handshakes and k_shift (rc_ladder_iir_if.slave)
//
// state | meaning
// IDLE  | waiting for a sample; clear is honoured here
// CALC  | updating section idx, one section per clock
// OUT   | result presented on out_data until out_ready
module rc_ladder_iir #(
  parameter int DATA_W  = 16,
  parameter int STAGES  = 2,
  parameter int GUARD   = 4,
  parameter int SHIFT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic busy,
  rc_ladder_iir_if.slave bus
);
  localparam int ACC_W = DATA_W + GUARD;
  localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [IDX_W-1:0]     LAST = IDX_W'(STAGES - 1);
  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (GUARD - 1);
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((2**(DATA_W-1)) - 1);
  localparam logic signed [ACC_W:0] MINV = (ACC_W+1)'(-(2**(DATA_W-1)));

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t                   state;
  logic signed [ACC_W-1:0]  s [STAGES];
  logic signed [ACC_W-1:0]  x;
  logic        [IDX_W-1:0]  idx;
  logic        [SHIFT_W-1:0] k_lat;

  logic signed [ACC_W-1:0]  cur;
  logic signed [ACC_W:0]    diff;
  logic signed [ACC_W:0]    step;
  logic signed [ACC_W:0]    nv_w;
  logic signed [ACC_W:0]    rnd;
  logic signed [ACC_W:0]    sh;
  logic signed [DATA_W-1:0] sat;

  // Shared datapath. The new state is a convex combination of x and s[idx],
  // so nv_w always fits ACC_W; the extra bit only protects the subtraction.
  always_comb begin
    cur  = s[idx];
    diff = {x[ACC_W-1], x} - {cur[ACC_W-1], cur};
    step = diff >>> k_lat;
    nv_w = {cur[ACC_W-1], cur} + step;
    rnd  = nv_w + HALF;
    sh   = rnd >>> GUARD;
    sat  = sh[DATA_W-1:0];
    if (sh > MAXV)      sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (sh < MINV) sat = {1'b1, {(DATA_W-1){1'b0}}};
  end

  assign bus.in_ready = rst_n && (state == IDLE) && !clear;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      for (int i = 0; i < STAGES; i++) s[i] <= '0;
      x             <= '0;
      idx           <= '0;
      k_lat         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            for (int i = 0; i < STAGES; i++) s[i] <= '0;
          end else if (bus.in_valid) begin
            x     <= {bus.in_data, {GUARD{1'b0}}};
            k_lat <= bus.k_shift;
            idx   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          s[idx] <= nv_w[ACC_W-1:0];
          x      <= nv_w[ACC_W-1:0];
          if (idx == LAST) begin
            state         <= OUT;
            bus.out_valid <= 1'b1;
            bus.out_data  <= sat;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
